// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns a clean level command into a bouncy
// switch line with LFSR-randomised gaps, then reports when it has settled.
module bounce_gen #(
    parameter int          EDGES      = 4,
    parameter int          GAP_MIN    = 4,
    parameter int          GAP_MASK_W = 3,
    parameter int          SETTLE     = 32,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic level_in,
    output logic sw_out,
    output logic busy,
    output logic done
);

    localparam int GAP_MAX = GAP_MIN + (1 << GAP_MASK_W) - 1;
    localparam int CNT_MAX = (GAP_MAX > SETTLE) ? GAP_MAX : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int EW      = $clog2(EDGES + 1);
    localparam int MW      = (GAP_MASK_W > 0) ? GAP_MASK_W : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE
    } state_t;

    state_t        state, state_d;
    logic          sw_d;
    logic          settled, settled_d;
    logic          target, target_d;
    logic [EW-1:0] edge_cnt, edge_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [15:0]   lfsr, lfsr_d;
    logic [15:0]   lfsr_nxt;
    logic          busy_d;
    logic          done_d;
    logic [MW-1:0] extra;
    logic [CW-1:0] gap_val;

    // cnt serves as the gap counter in BOUNCE and the settle counter in SETTLE
    always_comb begin
        extra    = (GAP_MASK_W > 0) ? lfsr[MW-1:0] : '0;
        gap_val  = CW'(GAP_MIN) + CW'(extra);
        lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb begin
        state_d   = state;
        sw_d      = sw_out;
        settled_d = settled;
        target_d  = target;
        edge_d    = edge_cnt;
        cnt_d     = cnt;
        lfsr_d    = lfsr;
        busy_d    = busy;
        done_d    = 1'b0;
        if (!enable) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            sw_d      = level_in;
            settled_d = level_in;
        end else begin
            unique case (state)
                S_IDLE: begin
                    sw_d = settled;
                    if (level_in != settled) begin
                        target_d = level_in;
                        sw_d     = ~sw_out;
                        edge_d   = EW'(1);
                        cnt_d    = gap_val;
                        lfsr_d   = lfsr_nxt;
                        busy_d   = 1'b1;
                        state_d  = S_BOUNCE;
                    end
                end
                S_BOUNCE: begin
                    if (cnt > CW'(1)) begin
                        cnt_d = cnt - CW'(1);
                    end else if (edge_cnt < EW'(EDGES)) begin
                        sw_d   = ~sw_out;
                        edge_d = edge_cnt + EW'(1);
                        cnt_d  = gap_val;
                        lfsr_d = lfsr_nxt;
                    end else begin
                        sw_d    = target;
                        cnt_d   = CW'(SETTLE);
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    sw_d = target;
                    if (cnt == CW'(1)) begin
                        settled_d = target;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            sw_out   <= 1'b0;
            settled  <= 1'b0;
            target   <= 1'b0;
            edge_cnt <= '0;
            cnt      <= '0;
            lfsr     <= SEED;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            sw_out   <= sw_d;
            settled  <= settled_d;
            target   <= target_d;
            edge_cnt <= edge_d;
            cnt      <= cnt_d;
            lfsr     <= lfsr_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: fixed-gap instance for waveform timing,
// random-gap instance for gap range, LFSR sequence and burst shape.
module tb_bounce_gen;

    localparam int G    = 4;
    localparam int DLAT = 25;
    localparam int BSET = 8;

    typedef struct packed {
        int   lbl;
        logic v;
    } ev_t;

    logic clk = 1'b0;
    logic rst_a, en_a, lvl_a, sw_a, busy_a, done_a;
    logic rst_b, en_b, lvl_b, sw_b, busy_b, done_b;

    int ecnt = 0;
    int checks = 0;
    int failures = 0;

    ev_t  swq_a[$];
    ev_t  doneq_a[$];
    int   gapq_b[$];
    ev_t  doneq_b[$];
    int   meas_b[$];
    int   first4[$];
    bit   mon_a = 1'b0;
    bit   mon_b = 1'b0;
    logic [15:0] mlfsr;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    bounce_gen #(
        .EDGES(4), .GAP_MIN(4), .GAP_MASK_W(0), .SETTLE(8), .SEED(16'hACE1)
    ) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .level_in(lvl_a),
        .sw_out(sw_a), .busy(busy_a), .done(done_a)
    );

    bounce_gen #(
        .EDGES(4), .GAP_MIN(4), .GAP_MASK_W(3), .SETTLE(8), .SEED(16'hACE1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .level_in(lvl_b),
        .sw_out(sw_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic unexpected(input string nm, input int act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=no_event", nm, act);
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // monitor A: every sw_out transition and done pulse is checked against the queue
    initial begin
        logic prev;
        ev_t  e;
        int   now;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            now = ecnt + 1;
            if (mon_a) begin
                if (sw_a !== prev) begin
                    if (swq_a.size() == 0) unexpected("a_sw_edge", now);
                    else begin
                        e = swq_a.pop_front();
                        chk("a_sw_time", now, e.lbl);
                        chk("a_sw_val", sw_a, e.v);
                    end
                end
                if (done_a === 1'b1) begin
                    if (doneq_a.size() == 0) unexpected("a_done", now);
                    else begin
                        e = doneq_a.pop_front();
                        chk("a_done_time", now, e.lbl);
                        chk("a_done_level", sw_a, e.v);
                    end
                end
            end
            prev = sw_a;
        end
    end

    // monitor B: gap lengths, transitions per burst, settle time, final level
    initial begin
        logic prev;
        ev_t  e;
        int   now, last, trans, g;
        prev  = 1'b0;
        last  = 0;
        trans = 0;
        forever begin
            @(negedge clk);
            now = ecnt + 1;
            if (!mon_b) trans = 0;
            else begin
                if (sw_b !== prev) begin
                    if (trans > 0) begin
                        g = now - last;
                        meas_b.push_back(g);
                        chk("b_gap_range", (g >= 4 && g <= 11), 1);
                        if (gapq_b.size() == 0) unexpected("b_gap", g);
                        else chk("b_gap", g, gapq_b.pop_front());
                    end
                    trans++;
                    last = now;
                end
                if (done_b === 1'b1) begin
                    chk("b_settle", now - last, BSET);
                    if (doneq_b.size() == 0) unexpected("b_done", now);
                    else begin
                        e = doneq_b.pop_front();
                        chk("b_edges", trans, e.lbl);
                        chk("b_final", sw_b, e.v);
                    end
                    trans = 0;
                end
            end
            prev = sw_b;
        end
    end

    // expected waveform of one fixed-gap burst whose change is sampled at edge t
    task automatic push_a(input int t, input logic lv);
        for (int i = 0; i < 5; i++)
            swq_a.push_back('{t + 1 + G * i, (i % 2 == 0) ? lv : ~lv});
        doneq_a.push_back('{t + DLAT, lv});
    endtask

    task automatic start_a(input logic lv, output int t);
        t = ecnt + 1;
        push_a(t, lv);
        lvl_a = lv;
    endtask

    task automatic wait_lbl(input int l);
        while (ecnt + 1 < l) @(negedge clk);
    endtask

    task automatic drain_a(input int budget);
        int n = 0;
        while ((swq_a.size() != 0 || doneq_a.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("a_drain", swq_a.size() + doneq_a.size(), 0);
        swq_a.delete();
        doneq_a.delete();
    endtask

    task automatic burst_b(input logic lv);
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            gapq_b.push_back(4 + int'(mlfsr[2:0]));
            mlfsr = step(mlfsr);
        end
        doneq_b.push_back('{5, lv});
        lvl_b = lv;
        do begin
            @(negedge clk);
            n++;
        end while (done_b !== 1'b1 && n < 200);
        chk("b_done_seen", done_b, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_a = 1'b0; en_a = 1'b1; lvl_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b1; lvl_b = 1'b0;
        mlfsr = 16'hACE1;
        repeat (3) @(negedge clk);
        chk("rst_sw_a", sw_a, 1'b0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_done_a", done_a, 1'b0);
        chk("rst_sw_b", sw_b, 1'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        mon_a = 1'b1;
        mon_b = 1'b1;

        // rising burst with busy window
        start_a(1'b1, t);
        wait_lbl(t + 1);
        chk("t1_busy_first", busy_a, 1'b1);
        wait_lbl(t + DLAT - 1);
        chk("t1_busy_last", busy_a, 1'b1);
        wait_lbl(t + DLAT);
        chk("t1_busy_off", busy_a, 1'b0);
        drain_a(10);

        // mirror falling burst
        start_a(1'b0, t);
        drain_a(40);

        // level jitter during bounce is ignored, then a new burst after done
        start_a(1'b1, t);
        push_a(t + DLAT, 1'b0);
        repeat (3) @(negedge clk);
        lvl_a = 1'b0;
        @(negedge clk);
        lvl_a = 1'b1;
        @(negedge clk);
        lvl_a = 1'b0;
        drain_a(80);
        chk("t3_final", sw_a, 1'b0);

        // asynchronous reset mid-burst
        start_a(1'b1, t);
        wait_lbl(t + 7);
        mon_a = 1'b0;
        #2 rst_a = 1'b0;
        #1;
        chk("t4_sw", sw_a, 1'b0);
        chk("t4_busy", busy_a, 1'b0);
        chk("t4_done", done_a, 1'b0);
        swq_a.delete();
        doneq_a.delete();
        lvl_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        mon_a = 1'b1;
        repeat (30) @(negedge clk);
        chk("t4_idle_sw", sw_a, 1'b0);
        start_a(1'b1, t);
        drain_a(40);

        // enable low mid-bounce aborts to level_in
        start_a(1'b0, t);
        wait_lbl(t + 6);
        mon_a = 1'b0;
        en_a = 1'b0;
        @(negedge clk);
        chk("t5_sw", sw_a, 1'b0);
        chk("t5_busy", busy_a, 1'b0);
        chk("t5_done", done_a, 1'b0);
        swq_a.delete();
        doneq_a.delete();
        repeat (3) @(negedge clk);
        en_a = 1'b1;
        mon_a = 1'b1;
        repeat (30) @(negedge clk);
        chk("t5_reen_sw", sw_a, 1'b0);
        chk("t5_reen_busy", busy_a, 1'b0);

        // random gaps: record first burst, reset mid-burst, repeat from SEED
        meas_b.delete();
        burst_b(1'b1);
        first4 = meas_b;
        chk("b_first_gap0", first4.size() > 0 ? first4[0] : -1, 5);
        chk("b_first_gap1", first4.size() > 1 ? first4[1] : -1, 7);
        mon_b = 1'b0;
        lvl_b = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("b_rst_sw", sw_b, 1'b0);
        chk("b_rst_busy", busy_b, 1'b0);
        gapq_b.delete();
        doneq_b.delete();
        mlfsr = 16'hACE1;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        mon_b = 1'b1;
        meas_b.delete();
        for (int i = 0; i < 100; i++) burst_b((i % 2 == 0) ? 1'b1 : 1'b0);
        for (int i = 0; i < 4; i++)
            chk("b_repeat_gap",
                meas_b.size() > i ? meas_b[i] : -1,
                first4.size() > i ? first4[i] : -2);
        repeat (3) @(negedge clk);
        chk("b_drain", gapq_b.size() + doneq_b.size(), 0);
        chk("b_end_level", sw_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
